// File: rtl/timer_pkg.sv
// Shared types and constants for the timer control stage and the timer it drives.
// The button priority helper lives here so every consumer resolves presses the same way.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        ALARM = 3'd4
    } timer_state_t;

    localparam int DIV_COUNT_DEF   = 10_000_000;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int LAP_STEP        = 30;

    typedef struct packed {
        logic clr;
        logic mode;
        logic start;
        logic add;
    } press_t;

    // Keep only the highest-priority press: clear > mode > start > add.
    function automatic press_t prioritize(press_t p);
        press_t r;
        r = '0;
        if (p.clr)        r.clr   = 1'b1;
        else if (p.mode)  r.mode  = 1'b1;
        else if (p.start) r.start = 1'b1;
        else if (p.add)   r.add   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between timer_ctrl and the countdown timer and display stages.
// master is the control stage; slave is the timer/display side.
interface timer_ctrl_if;
    logic       time_up;
    logic       enable_in;
    logic       enable_dec;
    logic       lap;
    logic       clear;
    logic       clk_div;
    logic       alarm;
    logic [2:0] state_o;

    modport master (
        input  time_up,
        output enable_in, enable_dec, lap, clear, clk_div, alarm, state_o
    );

    modport slave (
        output time_up,
        input  enable_in, enable_dec, lap, clear, clk_div, alarm, state_o
    );
endinterface

// File: rtl/timer_ctrl_btn_edge.sv
// Synchronizes one raw push-button and emits a single-cycle press on its rising edge.
// After reset a button must be seen released before it can generate a press.
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   prev_reg;
    logic                   armed_reg;

    // fill_reg marks when the synchronizer output reflects the pin rather than reset zeros.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync_reg  <= '0;
            fill_reg  <= '0;
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
            fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            if (fill_reg[SYNC_STAGES-1] && !sync_reg[SYNC_STAGES-1])
                armed_reg <= 1'b1;
        end
    end

    assign press = sync_reg[SYNC_STAGES-1] & ~prev_reg & armed_reg;

endmodule

// File: rtl/timer_ctrl.sv
// Mode state machine and strobe generator sitting in front of the countdown timer.
// Every output is registered and decoded from the next state.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DIV_COUNT   = DIV_COUNT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            btn_mode,
    input  logic            btn_start,
    input  logic            btn_add,
    input  logic            btn_clear,
    timer_ctrl_if.master    tmr
);

    localparam int PW = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);

    logic [3:0]   btn_raw_vec;
    logic [3:0]   press_vec;
    press_t       press;

    timer_state_t state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic         lap_next, clear_next, div_next;
    logic         en_in_reg, en_dec_reg, lap_reg, clear_reg, div_reg, alarm_reg;

    assign btn_raw_vec = {btn_clear, btn_mode, btn_start, btn_add};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
                .clk     (clk),
                .nrst    (nrst),
                .btn_raw (btn_raw_vec[gi]),
                .press   (press_vec[gi])
            );
        end
    endgenerate

    assign press = prioritize(press_t'(press_vec));

    always_comb begin
        state_next = state_reg;
        lap_next   = 1'b0;
        clear_next = 1'b0;
        div_next   = 1'b0;
        presc_next = '0;

        case (state_reg)
            IDLE: begin
                if (press.mode)       state_next = SET;
                else if (press.start) state_next = RUN;
            end
            SET: begin
                if (press.clr) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end else if (press.mode) begin
                    state_next = IDLE;
                end else if (press.start) begin
                    state_next = RUN;
                end else if (press.add) begin
                    lap_next = 1'b1;
                end
            end
            RUN: begin
                // Expiry outranks every button except clear.
                if (press.clr) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end else if (tmr.time_up) begin
                    state_next = ALARM;
                end else if (press.start) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (press.clr) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end else if (press.mode) begin
                    state_next = SET;
                end else if (press.start) begin
                    state_next = RUN;
                end
            end
            ALARM: begin
                if (press != '0) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A resumed run keeps the fractional second held during PAUSE.
        if (state_next == RUN) begin
            if (state_reg == RUN) begin
                if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    div_next   = 1'b1;
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end else if (state_reg == PAUSE) begin
                presc_next = presc_reg;
            end
        end else if (state_next == PAUSE) begin
            presc_next = presc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            en_in_reg  <= 1'b0;
            en_dec_reg <= 1'b0;
            lap_reg    <= 1'b0;
            clear_reg  <= 1'b0;
            div_reg    <= 1'b0;
            alarm_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            presc_reg  <= presc_next;
            en_in_reg  <= (state_next == SET);
            en_dec_reg <= (state_next == RUN);
            lap_reg    <= lap_next;
            clear_reg  <= clear_next;
            div_reg    <= div_next;
            alarm_reg  <= (state_next == ALARM);
        end
    end

    assign tmr.enable_in  = en_in_reg;
    assign tmr.enable_dec = en_dec_reg;
    assign tmr.lap        = lap_reg;
    assign tmr.clear      = clear_reg;
    assign tmr.clk_div    = div_reg;
    assign tmr.alarm      = alarm_reg;
    assign tmr.state_o    = state_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with DIV_COUNT=4: expected output words are queued
// against absolute cycle numbers as stimulus is driven, then checked on the falling edge.
module tb_timer_ctrl;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    logic btn_mode, btn_start, btn_add, btn_clear;

    timer_ctrl_if tif();

    timer_ctrl #(.DIV_COUNT(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .btn_mode  (btn_mode),
        .btn_start (btn_start),
        .btn_add   (btn_add),
        .btn_clear (btn_clear),
        .tmr       (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         cyc;
        logic [8:0] val;
    } sb_t;

    sb_t sb_q[$];
    int  cyc_cnt = 0;
    int  vec_cnt = 0;
    int  err_cnt = 0;
    int  lap_cnt = 0;
    int  clr_cnt = 0;
    int  div_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc_cnt, got, exp);
        end else begin
            $display("ok   %s cyc=%0d: %0h", tag, cyc_cnt, got);
        end
    endtask

    // {state_o, enable_in, enable_dec, lap, clear, clk_div, alarm}
    function automatic logic [8:0] pack(timer_state_t s, bit ein, bit edec, bit lp,
                                        bit cl, bit cd, bit al);
        return {s, ein, edec, lp, cl, cd, al};
    endfunction

    task automatic expect_at(input string tag, input int cyc, input logic [8:0] v);
        sb_t e;
        e.tag = tag;
        e.cyc = cyc;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [8:0] obs;
        sb_t        e;
        obs = {tif.state_o, tif.enable_in, tif.enable_dec, tif.lap,
               tif.clear, tif.clk_div, tif.alarm};
        if (tif.lap)     lap_cnt++;
        if (tif.clk_div) div_cnt++;
        if (tif.clear) begin
            clr_cnt++;
            check_eq("clear_enables_low", {30'd0, tif.enable_in, tif.enable_dec}, 32'd0);
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            e = sb_q.pop_front();
            check_eq(e.tag, {23'd0, obs}, {23'd0, e.val});
        end
    end

    initial begin
        int t, en, re, c;
        nrst = 1'b0; btn_mode = 1'b0; btn_start = 1'b0; btn_add = 1'b0;
        btn_clear = 1'b1;
        tif.time_up = 1'b0;

        // 1: reset with clear held; no clear pulse afterwards
        tick(3);
        nrst = 1'b1;
        t = cyc_cnt;
        for (int i = 1; i <= 6; i++) expect_at("reset_idle", t + i, 9'd0);
        tick(4);
        btn_clear = 1'b0;
        tick(6);
        #1 check_eq("reset_no_clear", clr_cnt, 0);

        // 2: mode then two adds
        t = cyc_cnt; btn_mode = 1'b1;
        expect_at("enter_set", t + 3, pack(SET, 1, 0, 0, 0, 0, 0));
        tick(5); btn_mode = 1'b0; tick(3);
        for (int k = 0; k < 2; k++) begin
            t = cyc_cnt; btn_add = 1'b1;
            expect_at("lap_pulse", t + 3, pack(SET, 1, 0, 1, 0, 0, 0));
            expect_at("lap_end",   t + 4, pack(SET, 1, 0, 0, 0, 0, 0));
            tick(5); btn_add = 1'b0; tick(3);
        end
        #1 check_eq("lap_count", lap_cnt, 2);

        // 3: run, ticks every 4, pause with prescaler frozen, resume
        t = cyc_cnt; btn_start = 1'b1; en = t + 3;
        expect_at("run_entry", en,     pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("run_pre",   en + 3, pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("div_4",     en + 4, pack(RUN, 0, 1, 0, 0, 1, 0));
        expect_at("div_4_end", en + 5, pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("div_8",     en + 8, pack(RUN, 0, 1, 0, 0, 1, 0));
        tick(5); btn_start = 1'b0;
        tick(6);
        btn_start = 1'b1;
        expect_at("pause_entry", en + 11, pack(PAUSE, 0, 0, 0, 0, 0, 0));
        tick(5); btn_start = 1'b0;
        expect_at("pause_hold", en + 16, pack(PAUSE, 0, 0, 0, 0, 0, 0));
        tick(5);
        t = cyc_cnt; btn_start = 1'b1; re = t + 3;
        expect_at("resume",     re,     pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("resume_pre", re + 1, pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("resume_div", re + 2, pack(RUN, 0, 1, 0, 0, 1, 0));
        tick(5); btn_start = 1'b0;

        // 4: time_up -> ALARM, any press -> IDLE with clear
        tick(1); tif.time_up = 1'b1;
        expect_at("alarm", cyc_cnt + 1, pack(ALARM, 0, 0, 0, 0, 0, 1));
        tick(1); tif.time_up = 1'b0;
        expect_at("alarm_hold", cyc_cnt + 2, pack(ALARM, 0, 0, 0, 0, 0, 1));
        tick(2);
        t = cyc_cnt; btn_add = 1'b1;
        expect_at("alarm_clear", t + 3, pack(IDLE, 0, 0, 0, 1, 0, 0));
        expect_at("alarm_idle",  t + 4, pack(IDLE, 0, 0, 0, 0, 0, 0));
        tick(5); btn_add = 1'b0; tick(3);
        #1 check_eq("clear_count_a", clr_cnt, 1);

        // 5: clear and start together in RUN
        t = cyc_cnt; btn_start = 1'b1; en = t + 3;
        expect_at("run2_entry", en, pack(RUN, 0, 1, 0, 0, 0, 0));
        tick(2); btn_start = 1'b0;
        tick(2);
        c = cyc_cnt; btn_start = 1'b1; btn_clear = 1'b1;
        expect_at("clr_start_clear", c + 3, pack(IDLE, 0, 0, 0, 1, 0, 0));
        expect_at("clr_start_idle",  c + 4, pack(IDLE, 0, 0, 0, 0, 0, 0));
        tick(5); btn_start = 1'b0; btn_clear = 1'b0;
        expect_at("clr_start_stay", c + 9, pack(IDLE, 0, 0, 0, 0, 0, 0));
        tick(10);
        #1 check_eq("clear_count_b", clr_cnt, 2);

        // 6: reset mid-RUN at prescaler 2, then a fresh run
        t = cyc_cnt; btn_start = 1'b1; en = t + 3;
        expect_at("run3_entry", en, pack(RUN, 0, 1, 0, 0, 0, 0));
        tick(2); btn_start = 1'b0;
        tick(3);
        nrst = 1'b0;
        expect_at("mid_reset",   en + 3, 9'd0);
        expect_at("mid_reset_2", en + 4, 9'd0);
        tick(2); nrst = 1'b1;
        expect_at("post_reset", en + 5, 9'd0);
        tick(6);
        t = cyc_cnt; btn_start = 1'b1; en = t + 3;
        expect_at("run4_entry", en,     pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("run4_pre",   en + 3, pack(RUN, 0, 1, 0, 0, 0, 0));
        expect_at("run4_div",   en + 4, pack(RUN, 0, 1, 0, 0, 1, 0));
        tick(3); btn_start = 1'b0;
        tick(5);
        #1;
        check_eq("div_count",      div_cnt, 4);
        check_eq("clear_count_c",  clr_cnt, 2);
        check_eq("lap_count_end",  lap_cnt, 2);
        check_eq("sb_drained",     sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
